memory_access: RTL and testbench

//  MEM stage of the 5-stage MIPS32 pipeline, between Execute and WriteBack.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_align.sv | 26 ++
 rtl/memory_access.sv | 79 +++++++
 tb/tb_memory_access.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the MEM pipeline stage.
package mem_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} mem_size_t;
    typedef enum logic {MS_IDLE, MS_WAIT} mem_state_t;
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        mem_size_t   size;
        logic        sgn;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
    } exmem_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: alignment check, byte-lane steering for stores and lane extraction/extension for loads.
module mem_align
    import mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rext
);
    logic [31:0] sh;
    always_comb begin
        sh         = rdata >> {lane, 3'b000};
        misaligned = size == SZ_HALF ? lane[0] : size == SZ_BYTE ? 1'b0 : |lane;
        be         = size == SZ_BYTE ? 4'b0001 << lane :
                     size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wlane      = size == SZ_BYTE ? {4{wdata[7:0]}} :
                     size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        rext       = size == SZ_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
                     size == SZ_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage holding the EX/MEM register and running req/ack data-memory accesses.
module memory_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_e,
    input  logic        reg_write_e,
    input  logic        mem_to_reg_e,
    input  logic        mem_write_e,
    input  mem_size_t   mem_size_e,
    input  logic        mem_signed_e,
    input  logic [31:0] alu_out_e,
    input  logic [31:0] write_data_e,
    input  logic [4:0]  write_reg_e,
    output logic        stall_m,
    output logic        reg_write_m,
    output logic        mem_to_reg_m,
    output logic [31:0] alu_out_m,
    output logic [31:0] read_data_m,
    output logic [4:0]  write_reg_m,
    output logic        addr_err_m,
    output logic        bus_err_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    exmem_t r;
    mem_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic misaligned, mem_op, go, wb_ok;
    logic [3:0] be;
    logic [31:0] wlane, rext;
    mem_align u_align (
        .size(r.size), .sgn(r.sgn), .lane(r.alu[1:0]), .wdata(r.wdata), .rdata(dmem_rdata),
        .misaligned(misaligned), .be(be), .wlane(wlane), .rext(rext)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= '0;
            state <= MS_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (!stall_m)
                r <= '{valid_e, reg_write_e, mem_to_reg_e, mem_write_e, mem_size_e,
                       mem_signed_e, alu_out_e, write_data_e, write_reg_e};
        end
    end
    // Outputs are gated with rst so the stage is silent during the reset cycle itself.
    always_comb begin
        mem_op       = r.valid & (r.mem_to_reg | r.mem_write);
        go           = mem_op & ~misaligned & ~rst;
        bus_err_m    = go & (state == MS_WAIT) & (cnt == CW'(TIMEOUT_CYCLES)) & ~dmem_ack;
        stall_m      = go & ~dmem_ack & ~bus_err_m;
        state_n      = stall_m ? MS_WAIT : MS_IDLE;
        cnt_n        = stall_m ? (state == MS_WAIT ? cnt + CW'(1) : CW'(1)) : '0;
        addr_err_m   = mem_op & misaligned & ~rst;
        wb_ok        = r.valid & ~rst & ~stall_m & ~addr_err_m & ~bus_err_m;
        reg_write_m  = wb_ok & r.reg_write;
        mem_to_reg_m = wb_ok & r.mem_to_reg;
        alu_out_m    = rst ? '0 : r.alu;
        read_data_m  = rst ? '0 : rext;
        write_reg_m  = rst ? '0 : r.wreg;
        dmem_req     = go;
        dmem_we      = go & r.mem_write;
        dmem_addr    = go ? {r.alu[31:2], 2'b00} : '0;
        dmem_be      = go ? be : '0;
        dmem_wdata   = go ? wlane : '0;
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scenario tasks plus a writeback scoreboard for the MEM stage.
module tb_memory_access;
    import mem_pkg::*;
    localparam int T = 16;
    logic clk = 0, rst = 1;
    logic valid_e = 0, reg_write_e = 0, mem_to_reg_e = 0, mem_write_e = 0, mem_signed_e = 0;
    mem_size_t mem_size_e = SZ_WORD;
    logic [31:0] alu_out_e = 0, write_data_e = 0, dmem_rdata = 0;
    logic [4:0] write_reg_e = 0;
    logic dmem_ack = 0;
    logic stall_m, reg_write_m, mem_to_reg_m, addr_err_m, bus_err_m, dmem_req, dmem_we;
    logic [31:0] alu_out_m, read_data_m, dmem_addr, dmem_wdata;
    logic [4:0] write_reg_m;
    logic [3:0] dmem_be;
    typedef struct packed {logic [4:0] wr; logic [31:0] data;} wb_t;
    wb_t sb[$];
    wb_t exp_wb, got_wb;
    int tests = 0, fails = 0;

    memory_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .reg_write_e(reg_write_e),
        .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e), .mem_size_e(mem_size_e),
        .mem_signed_e(mem_signed_e), .alu_out_e(alu_out_e), .write_data_e(write_data_e),
        .write_reg_e(write_reg_e), .stall_m(stall_m), .reg_write_m(reg_write_m),
        .mem_to_reg_m(mem_to_reg_m), .alu_out_m(alu_out_m), .read_data_m(read_data_m),
        .write_reg_m(write_reg_m), .addr_err_m(addr_err_m), .bus_err_m(bus_err_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && reg_write_m) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected reg=%0d alu=%h rdata=%h", write_reg_m, alu_out_m, read_data_m);
            end else begin
                exp_wb = sb.pop_front();
                got_wb = {write_reg_m, mem_to_reg_m ? read_data_m : alu_out_m};
                if (got_wb !== exp_wb) begin
                    fails++;
                    $display("FAIL wb_data got reg=%0d data=%h exp reg=%0d data=%h",
                             got_wb.wr, got_wb.data, exp_wb.wr, exp_wb.data);
                end
            end
        end
    end

    task automatic set_e(input logic v, rw, mtr, mw, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, wd, input logic [4:0] wr);
        valid_e = v; reg_write_e = rw; mem_to_reg_e = mtr; mem_write_e = mw;
        mem_size_e = mem_size_t'(sz); mem_signed_e = sg;
        alu_out_e = a; write_data_e = wd; write_reg_e = wr;
    endtask

    task automatic bubble();
        set_e(0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    endtask

    function automatic logic any_out();
        return |{stall_m, reg_write_m, mem_to_reg_m, alu_out_m, read_data_m, write_reg_m,
                 addr_err_m, bus_err_m, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata};
    endfunction

    task automatic test_reset();
        rst = 1;
        set_e(1, 1, 0, 0, 2'b10, 0, 32'hDEAD, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (any_out() !== 1'b0) begin fails++; $display("FAIL reset_outputs got nonzero exp all zero"); end
        @(posedge clk); #1;
        rst = 0;
        bubble();
        @(negedge clk);
        tests++;
        if ({reg_write_m, stall_m, dmem_req} !== 3'b000)
            begin fails++; $display("FAIL reset_state got rw/stall/req=%b exp 000", {reg_write_m, stall_m, dmem_req}); end
    endtask

    task automatic test_alu();
        @(posedge clk); #1;
        set_e(1, 1, 0, 0, 2'b10, 0, 32'h1234, 0, 3);
        sb.push_back({5'd3, 32'h1234});
        @(posedge clk); #1;
        bubble();
        @(negedge clk);
        tests++;
        if ({reg_write_m, alu_out_m, dmem_req, stall_m} !== {1'b1, 32'h1234, 1'b0, 1'b0})
            begin fails++; $display("FAIL alu_pass got rw=%b alu=%h req=%b stall=%b exp 1 1234 0 0",
                                    reg_write_m, alu_out_m, dmem_req, stall_m); end
    endtask

    task automatic test_lb();
        @(posedge clk); #1;
        set_e(1, 1, 1, 0, 2'b00, 1, 32'h103, 0, 4);
        sb.push_back({5'd4, 32'hFFFFFF80});
        @(posedge clk); #1;
        bubble();
        dmem_ack = 1; dmem_rdata = 32'h80FFFFFF;
        @(negedge clk);
        tests++;
        if ({dmem_req, dmem_be, dmem_addr, read_data_m, stall_m} !== {1'b1, 4'b1000, 32'h100, 32'hFFFFFF80, 1'b0})
            begin fails++; $display("FAIL lb_signed got req=%b be=%b addr=%h rd=%h stall=%b exp 1 1000 100 ffffff80 0",
                                    dmem_req, dmem_be, dmem_addr, read_data_m, stall_m); end
        @(posedge clk); #1;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic test_sh();
        @(posedge clk); #1;
        set_e(1, 0, 0, 1, 2'b01, 0, 32'h102, 32'hABCD, 0);
        @(posedge clk); #1;
        bubble();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({stall_m, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, reg_write_m} !==
                {1'b1, 1'b1, 1'b1, 4'b1100, 32'h100, 32'hABCDABCD, 1'b0})
                begin fails++; $display("FAIL sh_wait[%0d] got stall=%b req=%b we=%b be=%b addr=%h wd=%h exp 1 1 1 1100 100 abcdabcd",
                                        i, stall_m, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata); end
            @(posedge clk); #1;
        end
        dmem_ack = 1;
        @(negedge clk);
        tests++;
        if ({stall_m, dmem_req} !== 2'b01)
            begin fails++; $display("FAIL sh_complete got stall=%b req=%b exp 0 1", stall_m, dmem_req); end
        @(posedge clk); #1;
        dmem_ack = 0;
        @(negedge clk);
        tests++;
        if (dmem_req !== 1'b0) begin fails++; $display("FAIL sh_no_reissue got req=%b exp 0", dmem_req); end
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        set_e(1, 1, 1, 0, 2'b10, 0, 32'h101, 0, 5);
        @(posedge clk); #1;
        bubble();
        @(negedge clk);
        tests++;
        if ({addr_err_m, dmem_req, reg_write_m, stall_m} !== 4'b1000)
            begin fails++; $display("FAIL misaligned got aerr/req/rw/stall=%b exp 1000",
                                    {addr_err_m, dmem_req, reg_write_m, stall_m}); end
        @(negedge clk);
        tests++;
        if (addr_err_m !== 1'b0) begin fails++; $display("FAIL aerr_pulse got %b exp 0", addr_err_m); end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic seen = 0;
        @(posedge clk); #1;
        set_e(1, 1, 1, 0, 2'b01, 0, 32'h200, 0, 6);
        @(posedge clk); #1;
        bubble();
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus_err_m) begin
                seen = 1;
                tests++;
                if ({stall_m, reg_write_m} !== 2'b00)
                    begin fails++; $display("FAIL timeout_release got stall=%b rw=%b exp 0 0", stall_m, reg_write_m); end
            end else if (stall_m) n++;
        end
        tests++;
        if (!seen || n != T) begin fails++; $display("FAIL timeout_len got seen=%b stall_cycles=%0d exp 1 %0d", seen, n, T); end
        @(negedge clk);
        tests++;
        if ({bus_err_m, dmem_req} !== 2'b00)
            begin fails++; $display("FAIL timeout_after got berr=%b req=%b exp 0 0", bus_err_m, dmem_req); end
    endtask

    task automatic test_rst_wait();
        @(posedge clk); #1;
        set_e(1, 1, 1, 0, 2'b10, 0, 32'h300, 0, 7);
        @(posedge clk); #1;
        bubble();
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({stall_m, dmem_req} !== 2'b11) begin fails++; $display("FAIL rst_wait_pre got stall=%b req=%b exp 1 1", stall_m, dmem_req); end
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        tests++;
        if (any_out() !== 1'b0) begin fails++; $display("FAIL rst_wait_outputs got nonzero exp all zero"); end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        tests++;
        if ({stall_m, dmem_req} !== 2'b00) begin fails++; $display("FAIL rst_wait_post got stall=%b req=%b exp 0 0", stall_m, dmem_req); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz[6] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        logic        sg[6] = '{0, 0, 0, 1, 0, 1};
        logic        ld[6] = '{0, 1, 1, 1, 1, 1};
        logic [31:0] ad[6] = '{32'h55, 32'h104, 32'h106, 32'h102, 32'h107, 32'h101};
        logic [31:0] ex[6] = '{32'h55, 32'h88223344, 32'h22, 32'hFFFF8822, 32'h88, 32'h33};
        dmem_ack = 1; dmem_rdata = 32'h88223344;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_e(1, 1, ld[i], 0, sz[i], sg[i], ad[i], 0, 5'(8 + i));
            sb.push_back({5'(8 + i), ex[i]});
            @(negedge clk);
            tests++;
            if (stall_m !== 1'b0) begin fails++; $display("FAIL b2b_stall[%0d] got %b exp 0", i, stall_m); end
        end
        @(posedge clk); #1;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        dmem_ack = 0; dmem_rdata = 0;
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL b2b_drain got %0d pending exp 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_misaligned();
        test_timeout();
        test_rst_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
